pq_front: RTL and testbench
===========================

PQ_FRONT -- requirements
Module: pq_front

Interface
REQ-001 Parameter: CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  command FIFO not full.
REQ-006 Port: cmd_op  input  2  pq_op_t: OP_ENQ=1, OP_DEQ=2, OP_REPL=3; 0 illegal.
REQ-007 Port: cmd_kv  input  kv_t  key-value for ENQ/REPL.
REQ-008 Port: rsp_valid  output  1  response held.
REQ-009 Port: rsp_ready  input  1  downstream accepts response.
REQ-010 Port: rsp_kv  output  kv_t  dequeued pair; {KEY0,VAL0} for ENQ or error.
REQ-011 Port: rsp_err  output  1  command rejected or degraded.
REQ-012 Ports to the queue: pq_enq, pq_deq (out, 1), pq_kvi (out, kv_t), pq_kvo (in, kv_t), pq_full, pq_empty, pq_busy (in, 1).

Function
REQ-013 Command accepted when cmd_valid && cmd_ready; written to FIFO that edge; FIFO pointers wrap modulo CMD_DEPTH, count width $clog2(CMD_DEPTH)+1.
REQ-014 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when FIFO non-empty and pq_busy=0; ISSUE->RESP always; RESP->ISSUE on rsp_ready when FIFO non-empty and pq_busy=0, RESP->IDLE on rsp_ready otherwise; RESP holds while rsp_ready=0.
REQ-015 pq_enq/pq_deq asserted only in ISSUE, for exactly one cycle per command; pq_kvi = FIFO head kv in ISSUE, {KEY0,VAL0} otherwise.
REQ-016 ISSUE decision uses pq_full/pq_empty sampled that cycle: ENQ with pq_full=0 -> pq_enq=1; DEQ with pq_empty=0 -> pq_deq=1; REPL with pq_empty=0 -> pq_enq=pq_deq=1; REPL with pq_empty=1 -> pq_enq only, rsp_err=1.
REQ-017 Rejected, no pq strobe, rsp_err=1, rsp_kv={KEY0,VAL0}: ENQ/REPL with pq_full=1 (REPL only if also empty), DEQ with pq_empty=1, ENQ/REPL whose key equals KEY0, cmd_op=0.
REQ-018 For DEQ/REPL, rsp_kv is pq_kvo sampled in ISSUE (pre-edge head), registered into response at ISSUE->RESP edge.
REQ-019 Latency: command accepted at edge N into empty FIFO, queue idle -> ISSUE in cycle N+1, rsp_valid from edge N+2; throughput one command per two cycles.
REQ-020 rsp_valid, rsp_kv, rsp_err stable while rsp_valid && !rsp_ready; FIFO pops at ISSUE->RESP edge.
REQ-021 Simultaneous push and pop on full FIFO: cmd_ready=0, so no push; pop frees slot next cycle.
REQ-022 pq_busy=1 blocks IDLE/RESP->ISSUE; never aborts an ISSUE already entered.

Reset
REQ-023 rst low: FSM=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_kv={KEY0,VAL0}, pq_enq=pq_deq=0, immediately and asynchronously.
REQ-024 Reset mid-operation discards FIFO contents and pending response; queue contents unaffected by this block.

Configuration
REQ-025 Macro PQ_FRONT_STATS_EN defined: adds outputs stat_enq, stat_deq, stat_rej (16 bits each, saturating, reset 0) counting issued enqueues, issued dequeues, rejections; REPL increments both enq and deq.
REQ-026 Macro undefined: no counters, no stat ports; all other behaviour identical.

Structure
REQ-027 pq_op_t and OP_* constants belong in pq_pkg alongside kv_t, KEY0, VAL0.
REQ-028 Sub-module pq_front_fifo (synchronous FIFO, CMD_DEPTH x {pq_op_t,kv_t}) instantiated once.

Verification
REQ-029 Reset, ENQ key 5 -> pq_enq one cycle in ISSUE, rsp_valid two cycles after accept, rsp_err=0, rsp_kv={KEY0,VAL0}.
REQ-030 Queue holds keys 3,7; DEQ -> pq_deq one cycle, rsp_kv.key=3, rsp_err=0.
REQ-031 Empty queue, DEQ -> no strobe, rsp_err=1, rsp_kv.key=KEY0; REPL key 9 -> pq_enq only, rsp_err=1.
REQ-032 Queue holds 4; REPL key 2 -> pq_enq=pq_deq=1 same cycle, rsp_kv.key=4.
REQ-033 Push 5 commands, rsp_ready=0 -> cmd_ready drops after 4th accept (CMD_DEPTH=4), response held stable; release rsp_ready -> all 5 responses in order.
REQ-034 pq_busy=1 for 3 cycles with command queued -> no ISSUE until pq_busy=0; rst low mid-RESP -> rsp_valid=0 asynchronously, FIFO empty.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue front end: command opcodes, key-value pairs, FSM states.
package pq_pkg;

    localparam int unsigned KEY_W  = 8;
    localparam int unsigned VAL_W  = 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ENQ  = 2'd1,
        OP_DEQ  = 2'd2,
        OP_REPL = 2'd3
    } pq_op_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    localparam logic [KEY_W-1:0] KEY0 = '0;
    localparam logic [VAL_W-1:0] VAL0 = '0;
    localparam kv_t              KV0  = '{key: KEY0, val: VAL0};

    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } fsm_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pq_front_fifo.sv
// Synchronous command FIFO; push when not full, pop when not empty, head visible combinationally.
module pq_front_fifo
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pq_front.sv
// Command front end for a priority queue: buffers commands, issues one strobe per command, returns a response.
// Optional PQ_FRONT_STATS_EN adds saturating enqueue/dequeue/reject counters.
module pq_front
    import pq_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  kv_t         cmd_kv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output kv_t         rsp_kv,
    output logic        rsp_err,
    output logic        pq_enq,
    output logic        pq_deq,
    output kv_t         pq_kvi,
    input  kv_t         pq_kvo,
    input  logic        pq_full,
    input  logic        pq_empty,
    input  logic        pq_busy
`ifdef PQ_FRONT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_enq,
    output logic [STAT_W-1:0] stat_deq,
    output logic [STAT_W-1:0] stat_rej
`endif
);

    fsm_t  state_q, state_d;
    logic  rsp_valid_q, rsp_valid_d;
    kv_t   rsp_kv_q, rsp_kv_d;
    logic  rsp_err_q, rsp_err_d;

    cmd_t  head;
    cmd_t  push_data;
    logic  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic  issuing, can_issue, key_ok;
    logic  iss_enq, iss_deq, iss_rej, iss_err;
    kv_t   iss_kv;

    assign push_data = '{op: pq_op_t'(cmd_op), kv: cmd_kv};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    pq_front_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_data),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Issue decision for the FIFO head against the queue flags of this cycle.
    always_comb begin
        iss_enq = 1'b0;
        iss_deq = 1'b0;
        iss_rej = 1'b0;
        iss_err = 1'b0;
        iss_kv  = KV0;
        key_ok  = (head.kv.key != KEY0);
        case (head.op)
            OP_ENQ: begin
                if (key_ok && !pq_full) iss_enq = 1'b1;
                else                    iss_rej = 1'b1;
            end
            OP_DEQ: begin
                if (!pq_empty) begin
                    iss_deq = 1'b1;
                    iss_kv  = pq_kvo;
                end else begin
                    iss_rej = 1'b1;
                end
            end
            OP_REPL: begin
                if (!key_ok || (pq_full && pq_empty)) begin
                    iss_rej = 1'b1;
                end else if (!pq_empty) begin
                    iss_enq = 1'b1;
                    iss_deq = 1'b1;
                    iss_kv  = pq_kvo;
                end else begin
                    // Replace on an empty queue degrades to a plain insert.
                    iss_enq = 1'b1;
                    iss_err = 1'b1;
                end
            end
            default: iss_rej = 1'b1;
        endcase
        iss_err = iss_err | iss_rej;
    end

    assign issuing = (state_q == S_ISSUE);
    assign pq_enq  = issuing && iss_enq;
    assign pq_deq  = issuing && iss_deq;
    assign pq_kvi  = issuing ? head.kv : KV0;

    assign can_issue = !fifo_empty && !pq_busy;

    // Next-state and response registers; the FIFO pops as ISSUE hands over to RESP.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_kv_d    = rsp_kv_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_issue) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d     = S_RESP;
                fifo_pop    = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_kv_d    = iss_kv;
                rsp_err_d   = iss_err;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_kv_d    = KV0;
                    rsp_err_d   = 1'b0;
                    state_d     = can_issue ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_kv_q    <= KV0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_kv_q    <= rsp_kv_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_kv    = rsp_kv_q;
    assign rsp_err   = rsp_err_q;

`ifdef PQ_FRONT_STATS_EN
    logic [STAT_W-1:0] stat_enq_q, stat_deq_q, stat_rej_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_enq_q <= '0;
            stat_deq_q <= '0;
            stat_rej_q <= '0;
        end else if (issuing) begin
            if (iss_enq) stat_enq_q <= sat_inc(stat_enq_q);
            if (iss_deq) stat_deq_q <= sat_inc(stat_deq_q);
            if (iss_rej) stat_rej_q <= sat_inc(stat_rej_q);
        end
    end

    assign stat_enq = stat_enq_q;
    assign stat_deq = stat_deq_q;
    assign stat_rej = stat_rej_q;
`endif

endmodule

// File: tb/tb_pq_front.sv
// Directed self-checking bench for pq_front; queue flags and head value are driven directly.
module tb_pq_front;
    import pq_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    kv_t        cmd_kv;
    logic       rsp_valid;
    logic       rsp_ready;
    kv_t        rsp_kv;
    logic       rsp_err;
    logic       pq_enq;
    logic       pq_deq;
    kv_t        pq_kvi;
    kv_t        pq_kvo;
    logic       pq_full;
    logic       pq_empty;
    logic       pq_busy;
`ifdef PQ_FRONT_STATS_EN
    logic [15:0] stat_enq, stat_deq, stat_rej;
`endif

    int errors = 0;
    int checks = 0;
    int enq_cnt = 0;
    int deq_cnt = 0;
    logic [7:0] enq_log [$];

    pq_front #(.CMD_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_kv    (cmd_kv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_kv    (rsp_kv),
        .rsp_err   (rsp_err),
        .pq_enq    (pq_enq),
        .pq_deq    (pq_deq),
        .pq_kvi    (pq_kvi),
        .pq_kvo    (pq_kvo),
        .pq_full   (pq_full),
        .pq_empty  (pq_empty),
        .pq_busy   (pq_busy)
`ifdef PQ_FRONT_STATS_EN
        ,
        .stat_enq  (stat_enq),
        .stat_deq  (stat_deq),
        .stat_rej  (stat_rej)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor on the falling edge, where the combinational strobes are settled.
    always @(negedge clk) begin
        if (pq_enq) begin
            enq_cnt = enq_cnt + 1;
            enq_log.push_back(pq_kvi.key);
        end
        if (pq_deq) deq_cnt = deq_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] key, input logic [7:0] val);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_kv    = '{key: key, val: val};
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "/ready_timeout"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // One command through an idle front end: accept, ISSUE next cycle, response the cycle after.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] key, input logic [7:0] val,
                          input logic xe, input logic xd, input logic [15:0] xkv, input logic xerr);
        int e0, d0;
        e0 = enq_cnt;
        d0 = deq_cnt;
        send(tag, op, key, val);
        chk({tag, "/no_rsp_yet"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "/enq"}, 32'(pq_enq), 32'(xe));
        chk({tag, "/deq"}, 32'(pq_deq), 32'(xd));
        chk({tag, "/kvi"}, 32'(pq_kvi), 32'({key, val}));
        tick();
        chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/rsp_kv"}, 32'(rsp_kv), 32'(xkv));
        chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(xerr));
        chk({tag, "/strobe_off"}, 32'({pq_enq, pq_deq}), 32'd0);
        chk({tag, "/enq_pulses"}, 32'(enq_cnt - e0), 32'(xe));
        chk({tag, "/deq_pulses"}, 32'(deq_cnt - d0), 32'(xd));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "/rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int nrsp, nerr, e0;
        logic [15:0] held_kv;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_kv    = KV0;
        rsp_ready = 1'b0;
        pq_kvo    = KV0;
        pq_full   = 1'b0;
        pq_empty  = 1'b1;
        pq_busy   = 1'b0;

        #2;
        chk("reset/cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset/rsp_err",   32'(rsp_err),   32'd0);
        chk("reset/rsp_kv",    32'(rsp_kv),    32'd0);
        chk("reset/strobes",   32'({pq_enq, pq_deq}), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        do_cmd("enq5",      2'd1, 8'd5, 8'h55, 1'b1, 1'b0, 16'h0000, 1'b0);

        pq_empty = 1'b0;
        pq_kvo   = '{key: 8'd3, val: 8'h33};
        do_cmd("deq3",      2'd2, 8'd0, 8'h00, 1'b0, 1'b1, 16'h0333, 1'b0);

        pq_empty = 1'b1;
        pq_kvo   = KV0;
        do_cmd("deq_empty", 2'd2, 8'd0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_cmd("repl_empty",2'd3, 8'd9, 8'h99, 1'b1, 1'b0, 16'h0000, 1'b1);

        pq_empty = 1'b0;
        pq_kvo   = '{key: 8'd4, val: 8'h44};
        do_cmd("repl4",     2'd3, 8'd2, 8'h22, 1'b1, 1'b1, 16'h0444, 1'b0);

        pq_full  = 1'b1;
        do_cmd("enq_full",  2'd1, 8'd6, 8'h66, 1'b0, 1'b0, 16'h0000, 1'b1);
        pq_full  = 1'b0;
        do_cmd("enq_key0",  2'd1, 8'd0, 8'h12, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_cmd("op0",       2'd0, 8'd8, 8'h88, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Fill the FIFO while the queue is busy, then drain with the response held.
        enq_log.delete();
        pq_busy = 1'b1;
        send("fill0", 2'd1, 8'd10, 8'hA0);
        send("fill1", 2'd1, 8'd11, 8'hA1);
        send("fill2", 2'd1, 8'd12, 8'hA2);
        send("fill3", 2'd1, 8'd13, 8'hA3);
        chk("fill/ready_low", 32'(cmd_ready), 32'd0);
        chk("fill/no_issue",  32'(pq_enq),    32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_kv    = '{key: 8'd14, val: 8'hA4};
        pq_busy   = 1'b0;
        tick();
        chk("fill/still_full", 32'(cmd_ready),  32'd0);
        chk("fill/issue10",    32'(pq_kvi.key), 32'd10);
        tick();
        chk("fill/slot_freed", 32'(cmd_ready), 32'd1);
        chk("fill/rsp_valid",  32'(rsp_valid), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("fill/full_again", 32'(cmd_ready), 32'd0);
        held_kv = rsp_kv;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold/stable", 32'({rsp_valid, rsp_err, rsp_kv}), 32'({1'b1, 1'b0, held_kv}));
        end
        rsp_ready = 1'b1;
        nrsp = 0;
        nerr = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) begin
                nrsp++;
                if (rsp_err) nerr++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        chk("drain/responses", 32'(nrsp), 32'd5);
        chk("drain/errors",    32'(nerr), 32'd0);
        chk("drain/issued",    32'(enq_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < enq_log.size(); i++)
            chk("drain/order", 32'(enq_log[i]), 32'(10 + i));

        // Busy gating, ISSUE not aborted by busy, then reset in the middle of RESP.
        pq_busy = 1'b1;
        send("busy20", 2'd1, 8'd20, 8'hB0);
        send("busy21", 2'd1, 8'd21, 8'hB1);
        for (int i = 0; i < 3; i++) begin
            chk("busy/blocked", 32'({pq_enq, rsp_valid}), 32'd0);
            tick();
        end
        pq_busy = 1'b0;
        tick();
        chk("busy/issue20", 32'({pq_enq, pq_kvi.key}), 32'({1'b1, 8'd20}));
        pq_busy = 1'b1;
        #1;
        chk("busy/no_abort", 32'(pq_enq), 32'd1);
        tick();
        chk("busy/resp", 32'(rsp_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst/cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst/strobes",   32'({pq_enq, pq_deq}), 32'd0);
        e0 = enq_cnt;
        pq_busy = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst/fifo_empty", 32'(enq_cnt - e0), 32'd0);
        chk("rst/idle",       32'({rsp_valid, cmd_ready}), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
